// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of a synchronous-read instruction memory.
// Owns the PC, absorbs the one-cycle memory latency with a single in-flight slot,
// and hands instructions to decode over valid/ready at one word per cycle.
// Optional build macro FETCH_PC_WRAP_TRAP_EN: stop at the top of the address
// space instead of wrapping, and report it on the extra wrap_trap output.
module instr_fetch_unit #(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 15,
  parameter int               OPC_W    = 4,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
`ifdef FETCH_PC_WRAP_TRAP_EN
  output logic              wrap_trap,
`endif
  output logic              halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_valid_q, inflight_valid_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic [DATA_W-1:0]   instr_out_q, instr_out_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;

  logic                slot_free;
  logic                advance;
  logic                capture;
  logic                stop_hit;
  logic                wrap_stop;
  logic [OPC_W-1:0]    opcode;

`ifdef FETCH_PC_WRAP_TRAP_EN
  localparam logic [ADDR_W-1:0] PC_MAX = '1;
  // wrap_pend: the last address has been issued, no further fetches until it lands
  logic wrap_pend_q, wrap_pend_d;
  logic wrap_trap_q, wrap_trap_d;
  assign wrap_stop = wrap_pend_q;
  assign wrap_trap = wrap_trap_q;
`else
  assign wrap_stop = 1'b0;
`endif

  assign opcode    = imem_data[DATA_W-1 -: OPC_W];
  assign slot_free = !instr_valid_q || instr_ready;
  assign advance   = (state_q == S_FETCH) && (!inflight_valid_q || slot_free) &&
                     !branch_valid && !wrap_stop;
  assign capture   = inflight_valid_q && slot_free;
  assign stop_hit  = capture && ((opcode == HALT_OPC) || wrap_stop);

  // A stalled fetch re-reads its own address so the memory output is never lost.
  assign imem_addr   = advance ? pc_q : inflight_pc_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == S_HALT);

  // Next-state: start from IDLE/HALT, branch redirect, capture and PC advance in FETCH.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    instr_out_d      = instr_out_q;
    instr_pc_d       = instr_pc_q;
    instr_valid_d    = instr_valid_q;
`ifdef FETCH_PC_WRAP_TRAP_EN
    wrap_pend_d      = wrap_pend_q;
    wrap_trap_d      = wrap_trap_q;
`endif
    if (state_q != S_FETCH) begin
      // Nothing is in flight here; only a pending HALT word may still await decode.
      if (slot_free) instr_valid_d = 1'b0;
      if (start) begin
        state_d          = S_FETCH;
        pc_d             = start_addr;
        inflight_valid_d = 1'b0;
`ifdef FETCH_PC_WRAP_TRAP_EN
        wrap_pend_d      = 1'b0;
        wrap_trap_d      = 1'b0;
`endif
      end
    end else if (branch_valid) begin
      // Redirect squashes both the in-flight word and the presented word.
      pc_d             = branch_target;
      inflight_valid_d = 1'b0;
      instr_valid_d    = 1'b0;
`ifdef FETCH_PC_WRAP_TRAP_EN
      wrap_pend_d      = 1'b0;
`endif
    end else begin
      if (capture) begin
        instr_out_d   = imem_data;
        instr_pc_d    = inflight_pc_q;
        instr_valid_d = 1'b1;
      end else if (slot_free) begin
        instr_valid_d = 1'b0;
      end
      if (stop_hit) begin
        // The stopping word is still delivered; the PC stays where it is.
        state_d          = S_HALT;
        inflight_valid_d = 1'b0;
`ifdef FETCH_PC_WRAP_TRAP_EN
        wrap_trap_d      = wrap_pend_q;
        wrap_pend_d      = 1'b0;
`endif
      end else if (advance) begin
        inflight_pc_d    = pc_q;
        inflight_valid_d = 1'b1;
`ifdef FETCH_PC_WRAP_TRAP_EN
        if (pc_q == PC_MAX) wrap_pend_d = 1'b1;
        else                pc_d        = pc_q + 1'b1;
`else
        pc_d             = pc_q + 1'b1;
`endif
      end
    end
  end

  // State, PC, in-flight slot and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      pc_q             <= '0;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      instr_out_q      <= '0;
      instr_pc_q       <= '0;
      instr_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      instr_out_q      <= instr_out_d;
      instr_pc_q       <= instr_pc_d;
      instr_valid_q    <= instr_valid_d;
    end
  end

`ifdef FETCH_PC_WRAP_TRAP_EN
  // Wrap-trap bookkeeping flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_pend_q <= 1'b0;
      wrap_trap_q <= 1'b0;
    end else begin
      wrap_pend_q <= wrap_pend_d;
      wrap_trap_q <= wrap_trap_d;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 15;
`ifdef FETCH_PC_WRAP_TRAP_EN
  localparam bit WRAP_TRAP = 1'b1;
`else
  localparam bit WRAP_TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          branch_valid = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data = '0;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          halted;
`ifdef FETCH_PC_WRAP_TRAP_EN
  logic          wrap_trap;
`endif

  logic [DW-1:0] mem [256];
  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
`ifdef FETCH_PC_WRAP_TRAP_EN
    .wrap_trap(wrap_trap),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 fetching, 2 halted. m_pc: next address to request.
  // m_fly: addresses requested from memory but not yet handed to decode.
  // m_ov/m_opc: the word decode currently sees (its data is simply mem[m_opc]).
  int            m_st = 0;
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_fly[$];
  logic          m_ov = 1'b0;
  logic [AW-1:0] m_opc = '0;
  logic          m_pend = 1'b0;
  logic          m_trap = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = 0; m_pc = '0; m_fly.delete(); m_ov = 1'b0; m_opc = '0;
      m_pend = 1'b0; m_trap = 1'b0;
    end else if (m_st != 1) begin
      if (m_ov && instr_ready) m_ov = 1'b0;
      if (start) begin
        m_st = 1; m_pc = start_addr; m_fly.delete(); m_pend = 1'b0; m_trap = 1'b0;
      end
    end else if (branch_valid) begin
      m_pc = branch_target; m_fly.delete(); m_ov = 1'b0; m_pend = 1'b0;
    end else begin
      automatic bit free  = !m_ov || instr_ready;
      automatic bit issue = (m_fly.size() == 0 || free) && !m_pend;
      if (m_ov && instr_ready) m_ov = 1'b0;
      if (free && m_fly.size() != 0) begin
        m_opc = m_fly.pop_front();
        m_ov  = 1'b1;
        if (mem[m_opc][DW-1 -: 4] == 4'hF || m_pend) begin
          m_st = 2; m_trap = m_pend; m_pend = 1'b0; issue = 1'b0;
        end
      end
      if (issue) begin
        m_fly.push_back(m_pc);
        if (WRAP_TRAP && m_pc == 8'hFF) m_pend = 1'b1;
        else                            m_pc   = m_pc + 8'd1;
      end
    end
  end

  // Compare DUT against the model mid-cycle.
  initial forever begin
    @(negedge clk);
    begin
      automatic bit exp_adv = rst_n && (m_st == 1) && !branch_valid && !m_pend &&
                              (m_fly.size() == 0 || !m_ov || instr_ready);
      chk("valid", instr_valid, m_ov);
      chk("halted", halted, m_st == 2);
`ifdef FETCH_PC_WRAP_TRAP_EN
      chk("wrap_trap", wrap_trap, m_trap);
`endif
      if (!rst_n) begin
        chk("rst_pc", instr_pc, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_imem_addr", imem_addr, 0);
      end else begin
        if (m_ov) begin
          chk("instr_pc", instr_pc, m_opc);
          chk("instr_out", instr_out, mem[m_opc]);
        end
        if (exp_adv)                 chk("imem_addr_adv", imem_addr, m_pc);
        else if (m_fly.size() != 0)  chk("imem_addr_hold", imem_addr, m_fly[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i);
    mem[8'h20] = 15'h7800;
    #2 rst_n = 1'b0;
    step(2);
    chk("reset_valid", instr_valid, 0);
    chk("reset_halted", halted, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_out", instr_out, 0);
    chk("reset_pc", instr_pc, 0);
    rst_n = 1'b1; instr_ready = 1'b1;
    step(1);

    // Start at 0x10: first word two edges after the start edge.
    start = 1'b1; start_addr = 8'h10;
    step(1); start = 1'b0;
    chk("start_addr", imem_addr, 8'h10);
    chk("lat0_valid", instr_valid, 0);
    step(1); chk("lat1_valid", instr_valid, 0);
    step(1);
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 8'h10);
    chk("first_out", instr_out, 15'h10);
    step(1); chk("seq_pc_11", instr_pc, 8'h11);
    step(1); chk("seq_pc_12", instr_pc, 8'h12);

    // Three stalled cycles on 0x12.
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("stall_pc", instr_pc, 8'h12);
      chk("stall_out", instr_out, 15'h12);
      chk("stall_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    step(1); chk("resume_pc_13", instr_pc, 8'h13);
    step(1); chk("resume_pc_14", instr_pc, 8'h14);
    step(1); chk("pre_branch_pc_15", instr_pc, 8'h15);

    // Branch while 0x15 is presented.
    branch_valid = 1'b1; branch_target = 8'h80;
    step(1); branch_valid = 1'b0;
    chk("branch_drop_valid", instr_valid, 0);
    step(1); chk("branch_gap_valid", instr_valid, 0);
    step(1);
    chk("branch_tgt_valid", instr_valid, 1);
    chk("branch_tgt_pc", instr_pc, 8'h80);
    chk("branch_tgt_out", instr_out, 15'h80);

    // start while fetching has no effect.
    start = 1'b1; start_addr = 8'h55;
    step(1); start = 1'b0;
    chk("start_ignored_pc", instr_pc, 8'h81);

    // Async reset while stalled.
    instr_ready = 1'b0;
    step(2);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("async_rst_valid", instr_valid, 0);
    chk("async_rst_pc", instr_pc, 0);
    chk("async_rst_out", instr_out, 0);
    chk("async_rst_addr", imem_addr, 0);
    step(2);
    rst_n = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1); chk("post_rst_idle_valid", instr_valid, 0);
    end

    // HALT word at 0x20.
    start = 1'b1; start_addr = 8'h1E;
    step(1); start = 1'b0;
    step(2); chk("halt_seq_1e", instr_pc, 8'h1E);
    step(1); chk("halt_seq_1f", instr_pc, 8'h1F); chk("halt_not_yet", halted, 0);
    step(1);
    chk("halt_word_pc", instr_pc, 8'h20);
    chk("halt_word_out", instr_out, 15'h7800);
    chk("halt_word_valid", instr_valid, 1);
    chk("halted_set", halted, 1);
    branch_valid = 1'b1; branch_target = 8'h40;
    step(1); chk("halt_branch_valid", instr_valid, 0); chk("halt_branch_halted", halted, 1);
    step(1); chk("halt_branch_valid2", instr_valid, 0); chk("halt_branch_halted2", halted, 1);
    start = 1'b1; start_addr = 8'h30;
    step(1); start = 1'b0; branch_valid = 1'b0;
    chk("restart_halted", halted, 0);
    step(2);
    chk("restart_valid", instr_valid, 1);
    chk("restart_pc", instr_pc, 8'h30);

    // Top of address space.
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    start = 1'b1; start_addr = 8'hFE;
    step(1); start = 1'b0;
    step(2); chk("wrap_fe", instr_pc, 8'hFE);
    step(1); chk("wrap_ff", instr_pc, 8'hFF);
`ifdef FETCH_PC_WRAP_TRAP_EN
    chk("wrap_trap_halted", halted, 1);
    chk("wrap_trap_flag", wrap_trap, 1);
    step(1); chk("wrap_trap_no_more", instr_valid, 0);
`else
    chk("wrap_not_halted", halted, 0);
    step(1);
    chk("wrap_00_pc", instr_pc, 8'h00);
    chk("wrap_00_valid", instr_valid, 1);
    chk("wrap_00_out", instr_out, 15'h0);
`endif

    // Randomized traffic on random memory contents.
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    step(1); rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      start         = ($urandom_range(0, 7) == 0);
      start_addr    = AW'($urandom);
      branch_valid  = ($urandom_range(0, 15) == 0);
      branch_target = AW'($urandom);
      instr_ready   = ($urandom_range(0, 3) != 0);
      step(1);
    end
    start = 1'b0; branch_valid = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the vertex processor, directly upstream of the 15-bit synchronous-read instruction memory.
- Owns the program counter and drives the memory's fetch address. Absorbs the memory's one-cycle read latency.
- Presents fetched instructions to decode over a valid/ready handshake at 1 instr/cycle.
- Handles start, branch redirect, downstream stall and a HALT opcode.

Parameters:
- ADDR_W, 8, instruction address width (PC width).
- DATA_W, 15, instruction word width.
- OPC_W, 4, opcode field width, taken from instruction bits [DATA_W-1 -: OPC_W].
- HALT_OPC, 4'hF, opcode value that stops fetching.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetching at start_addr (IDLE/HALT only).
- start_addr  in  ADDR_W  first fetch address.
- branch_valid  in  1  redirect request from execute.
- branch_target  in  ADDR_W  redirect address.
- imem_addr  out  ADDR_W  read address to instruction memory (combinational).
- imem_data  in  DATA_W  memory read data, valid one cycle after address sampled.
- instr_out  out  DATA_W  registered instruction to decode.
- instr_pc  out  ADDR_W  address of instr_out.
- instr_valid  out  1  instr_out valid.
- instr_ready  in  1  decode accepts instr_out this cycle.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0; inflight_valid=0; inflight_pc=0; instr_out=0; instr_pc=0; instr_valid=0; halted=0. imem_addr reads 0.
- States and transitions:
  - IDLE -> FETCH on start. pc<=start_addr; inflight cleared.
  - FETCH -> HALT when a word with opcode HALT_OPC is captured into the output register.
  - HALT -> FETCH on start, same as from IDLE.
- Definitions:
  - slot_free = !instr_valid || instr_ready.
  - advance = (state==FETCH) && (!inflight_valid || slot_free) && !branch_valid.
- imem_addr = advance ? pc : inflight_pc. When stalled, the in-flight address is re-read, so memory data is never lost.
- On an advance edge: pc<=pc+1, inflight_pc<=pc, inflight_valid<=1. Without the optional feature, pc wraps from 2**ADDR_W-1 to 0.
- Capture: at an edge with inflight_valid && slot_free, instr_out<=imem_data, instr_pc<=inflight_pc, instr_valid<=1.
- If slot_free and nothing is captured, instr_valid<=0.
- Latency:
  - start at edge 0 -> first address presented after edge 0.
  - instr_valid rises after edge 2.
  - Sustained 1 instr/cycle while instr_ready=1.
- Stall: instr_valid=1 && instr_ready=0 holds instr_out, instr_pc and pc stable. Exactly one word stays in flight, and no instruction is dropped or duplicated.
- HALT capture: the HALT word is delivered with instr_valid=1. At the same edge, inflight_valid<=0, pc is frozen, state=HALT, and halted=1 from the next cycle. The HALT word stays valid until accepted.
- Branch (FETCH only, highest priority after reset):
  - pc<=branch_target; inflight_valid<=0; instr_valid<=0, even if instr_ready=1 that cycle.
  - The first target word appears 2 cycles later.
- branch_valid is ignored in IDLE and HALT.
- start is ignored in FETCH.
- start and branch_valid in the same IDLE/HALT cycle: start wins.
- Reset mid-operation: returns immediately to reset values. In-flight and output words are discarded.

Optional Feature:
- Macro: FETCH_PC_WRAP_TRAP_EN.
- Defined: an advance with pc==2**ADDR_W-1 does not wrap.
  - The word at that address is fetched normally.
  - pc is then frozen and the state becomes HALT after that word is captured.
  - Added output port wrap_trap (1 bit) is set with halted; it clears on reset or start.
- Undefined: pc wraps to 0, and the port wrap_trap does not exist.

Test Plan:
- Reset, memory preloaded mem[i]=i, start_addr=0x10, instr_ready=1 -> instr_valid rises 2 cycles after start; instr_pc=0x10,0x11,0x12… on consecutive cycles; instr_out equals the address.
- Stall: instr_ready=0 for 3 cycles while instr_pc=0x12 -> instr_out/instr_pc held. After release, sequence continues 0x13,0x14 with no gap or duplicate.
- Branch: branch_valid=1, target=0x80, asserted while 0x15 is valid -> 0x15 dropped; next valid is instr_pc=0x80 two cycles later.
- HALT: mem[0x20]=15'h7800 (opcode F), start_addr=0x1E -> words 0x1E,0x1F,0x20 delivered; halted=1 afterwards; branch_valid then ignored; new start resumes.
- Wrap: start_addr=0xFE -> pc sequence 0xFE,0xFF,0x00. With FETCH_PC_WRAP_TRAP_EN: halts after 0xFF and wrap_trap=1.
- Async reset asserted mid-stream while stalled -> all outputs zero immediately; instr_valid=0; no output until a new start.
